// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 16-bit data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_write,
  output logic              dmem_read,
  input  logic [DATA_W-1:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state, state_nxt;
  logic   we_q;
  logic   owner_q;
  logic   gnt0, gnt1;
  logic   take;

`ifdef DMEM_ARB_RR_EN
  // 1 = port 1 granted last, so port 0 wins the next contention
  logic   last_q;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && rst_n) begin
`ifdef DMEM_ARB_RR_EN
      if (p0_req_valid && p1_req_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = p0_req_valid;
        gnt1 = p1_req_valid;
      end
`else
      gnt0 = p0_req_valid;
      gnt1 = p1_req_valid && !p0_req_valid;
`endif
    end
  end

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;
  assign take         = gnt0 | gnt1;

  always_comb begin
    state_nxt    = state;
    dmem_write   = 1'b0;
    dmem_read    = 1'b0;
    p0_rsp_valid = 1'b0;
    p1_rsp_valid = 1'b0;
    rsp_data     = '0;
    unique case (state)
      IDLE: begin
        if (take) state_nxt = ISSUE;
      end
      ISSUE: begin
        dmem_write = we_q;
        dmem_read  = !we_q;
        state_nxt  = we_q ? IDLE : RESP;
      end
      RESP: begin
        rsp_data     = dmem_rdata;
        p0_rsp_valid = !owner_q;
        p1_rsp_valid = owner_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dmem_address <= '0;
      dmem_wdata   <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner_q      <= gnt1;
        we_q         <= gnt1 ? p1_req_we    : p0_req_we;
        dmem_address <= gnt1 ? p1_req_addr  : p0_req_addr;
        dmem_wdata   <= gnt1 ? p1_req_wdata : p0_req_wdata;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else if (take) last_q <= gnt1;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// A small registered-read memory model sits behind the dmem port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
  logic [15:0] p0_req_addr, p0_req_wdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
  logic [15:0] p1_req_addr, p1_req_wdata;
  logic [15:0] rsp_data, dmem_address, dmem_wdata, dmem_rdata;
  logic        dmem_write, dmem_read;
  logic        preload;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .rsp_data(rsp_data), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_write(dmem_write),
    .dmem_read(dmem_read), .dmem_rdata(dmem_rdata)
  );

  always @(posedge clk) begin
    if (preload) begin
      mem[8'h01] <= 16'h1111;
      mem[8'h02] <= 16'h2222;
      mem[8'h20] <= 16'h1234;
    end else begin
      if (dmem_read) dmem_rdata <= mem[dmem_address[7:0]];
      if (dmem_write) mem[dmem_address[7:0]] <= dmem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at the negedge inside the ISSUE cycle of the request.
  task automatic req(input bit port, input bit we,
                     input logic [15:0] a, input logic [15:0] d);
    bit done = 1'b0;
    @(negedge clk);
    if (port) begin
      p1_req_valid = 1'b1; p1_req_we = we;
      p1_req_addr = a; p1_req_wdata = d;
    end else begin
      p0_req_valid = 1'b1; p0_req_we = we;
      p0_req_addr = a; p0_req_wdata = d;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (port ? p1_req_ready : p0_req_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check("req_timeout", 0, 1);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
  endtask

  logic [3:0] exp_gnt;
  int         n;

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    p0_req_valid = 0; p0_req_we = 0; p0_req_addr = 0; p0_req_wdata = 0;
    p1_req_valid = 0; p1_req_we = 0; p1_req_addr = 0; p1_req_wdata = 0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    check("rst_addr", dmem_address, 16'h0);
    check("rst_wdata", dmem_wdata, 16'h0);
    check("rst_strobes", {dmem_write, dmem_read}, 2'b00);
    check("rst_rsp", {p0_rsp_valid, p1_rsp_valid}, 2'b00);
    check("rst_rdata", rsp_data, 16'h0);
    check("rst_ready", {p0_req_ready, p1_req_ready}, 2'b00);
    p0_req_valid = 1'b1;
    #1 check("rst_ready_held", p0_req_ready, 1'b0);
    @(negedge clk);
    check("rst_ready_held2", p0_req_ready, 1'b0);
    p0_req_valid = 1'b0;
    rst_n = 1'b1;

    // p0 write then read back
    req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    check("wr_strobe", {dmem_write, dmem_read}, 2'b10);
    check("wr_addr", dmem_address, 16'h0010);
    check("wr_data", dmem_wdata, 16'hBEEF);
    @(negedge clk);
    check("wr_one_cycle", dmem_write, 1'b0);
    req(1'b0, 1'b0, 16'h0010, 16'h0);
    check("rd_strobe", {dmem_write, dmem_read}, 2'b01);
    check("rd_no_early_rsp", p0_rsp_valid, 1'b0);
    @(negedge clk);
    check("rd_p0_rsp", {p0_rsp_valid, p1_rsp_valid}, 2'b10);
    check("rd_data", rsp_data, 16'hBEEF);
    @(negedge clk);
    check("rd_pulse", p0_rsp_valid, 1'b0);
    check("rd_data_zero", rsp_data, 16'h0);

    // p1 read of preloaded word
    req(1'b1, 1'b0, 16'h0020, 16'h0);
    check("p1_rd_addr", dmem_address, 16'h0020);
    @(negedge clk);
    check("p1_rsp", {p0_rsp_valid, p1_rsp_valid}, 2'b01);
    check("p1_data", rsp_data, 16'h1234);

    // contention; p1 was granted last
`ifdef DMEM_ARB_RR_EN
    exp_gnt = 4'b1010;
`else
    exp_gnt = 4'b0000;
`endif
    @(negedge clk);
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 16'h0001;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 16'h0002;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (p0_rsp_valid) check("ctn_p0_data", rsp_data, 16'h1111);
      if (p1_rsp_valid) check("ctn_p1_data", rsp_data, 16'h2222);
      if (p0_req_ready || p1_req_ready) begin
        check("ctn_one_ready", p0_req_ready & p1_req_ready, 1'b0);
        check($sformatf("ctn_grant%0d", n), p1_req_ready, exp_gnt[n]);
        n++;
      end
      @(negedge clk);
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    check("ctn_count", n, 4);
    @(negedge clk);
    check("ctn_last_rsp", {p0_rsp_valid, p1_rsp_valid},
          {!exp_gnt[3], exp_gnt[3]});
    @(negedge clk);

    // reset during ISSUE of a p0 read
    req(1'b0, 1'b0, 16'h0010, 16'h0);
    check("mid_rd_issue", dmem_read, 1'b1);
    rst_n = 1'b0;
    #1 check("mid_rst_strobe", dmem_read, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", p0_rsp_valid, 1'b0);
    end
    rst_n = 1'b1;
    p1_req_valid = 1'b1; p1_req_we = 1'b1;
    p1_req_addr = 16'h0030; p1_req_wdata = 16'h5A5A;
    #1 check("post_rst_ready", p1_req_ready, 1'b1);
    @(negedge clk);
    p1_req_valid = 1'b0;
    check("post_rst_no_rsp", p0_rsp_valid, 1'b0);
    check("post_rst_wr", {dmem_write, dmem_address}, {1'b1, 16'h0030});
    req(1'b0, 1'b0, 16'h0030, 16'h0);
    @(negedge clk);
    check("post_rst_rdback", rsp_data, 16'h5A5A);
    @(negedge clk);

    // back-to-back writes with valid held
    p0_req_valid = 1'b1; p0_req_we = 1'b1;
    p0_req_addr = 16'h0040; p0_req_wdata = 16'h0F0F;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("b2b_ready%0d", k), p0_req_ready, (k % 2) == 0);
      check($sformatf("b2b_noread%0d", k), dmem_read, 1'b0);
      @(negedge clk);
    end
    p0_req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
